// File: rtl/stream_xor_encryptor.sv
// Byte-serial XOR stream-cipher stage: requests one keystream byte per plaintext byte from the
// hash generator, XORs it in, and hands the result downstream over valid/ready.
module stream_xor_encryptor #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned COUNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   restart,
  input  logic [7:0]             plain_byte_in,
  input  logic                   plain_valid_in,
  output logic                   plain_ready_out,
  output logic [7:0]             cipher_byte_out,
  output logic                   cipher_valid_out,
  input  logic                   cipher_ready_in,
  output logic                   request_hash_byte_pulse_out,
  input  logic [7:0]             hash_byte_in,
  input  logic                   hash_byte_pulse_in,
  output logic                   reset_hash_out,
  output logic [COUNT_WIDTH-1:0] byte_count_out,
  output logic                   timeout_error_out
);

  localparam int unsigned TmoWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoWidth-1:0] TmoLimit = TmoWidth'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StRequest,
    StWaitHash,
    StOutput,
    StError
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             plain_q, plain_d;
  logic [7:0]             cipher_q, cipher_d;
  logic                   valid_q, valid_d;
  logic                   req_q, req_d;
  logic                   reset_hash_q, reset_hash_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   error_q, error_d;
  logic [TmoWidth-1:0]    tmo_q, tmo_d;
  logic [TmoWidth-1:0]    tmo_inc;

  // The cycle after a restart is reserved for the generator's own reset.
  assign plain_ready_out = (state_q == StIdle) && !reset_hash_q;
  assign tmo_inc         = tmo_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    plain_d      = plain_q;
    cipher_d     = cipher_q;
    valid_d      = valid_q;
    req_d        = 1'b0;
    reset_hash_d = 1'b0;
    count_d      = count_q;
    error_d      = error_q;
    tmo_d        = tmo_q;

    unique case (state_q)
      StIdle: begin
        if (plain_valid_in && plain_ready_out) begin
          plain_d = plain_byte_in;
          req_d   = 1'b1;
          state_d = StRequest;
        end
      end
      StRequest: begin
        tmo_d   = '0;
        state_d = StWaitHash;
      end
      StWaitHash: begin
        // A pulse on the limit cycle still wins over the timeout.
        if (hash_byte_pulse_in) begin
          cipher_d = plain_q ^ hash_byte_in;
          valid_d  = 1'b1;
          state_d  = StOutput;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TmoLimit) begin
            error_d = 1'b1;
            state_d = StError;
          end
        end
      end
      StOutput: begin
        if (cipher_ready_in) begin
          valid_d = 1'b0;
          count_d = count_q + 1'b1;
          state_d = StIdle;
        end
      end
      StError: begin
        state_d = StError;
      end
      default: state_d = StIdle;
    endcase

    if (restart) begin
      state_d      = StIdle;
      plain_d      = '0;
      valid_d      = 1'b0;
      req_d        = 1'b0;
      count_d      = '0;
      error_d      = 1'b0;
      tmo_d        = '0;
      reset_hash_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      plain_q      <= '0;
      cipher_q     <= '0;
      valid_q      <= 1'b0;
      req_q        <= 1'b0;
      reset_hash_q <= 1'b0;
      count_q      <= '0;
      error_q      <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      plain_q      <= plain_d;
      cipher_q     <= cipher_d;
      valid_q      <= valid_d;
      req_q        <= req_d;
      reset_hash_q <= reset_hash_d;
      count_q      <= count_d;
      error_q      <= error_d;
      tmo_q        <= tmo_d;
    end
  end

  assign cipher_byte_out             = cipher_q;
  assign cipher_valid_out            = valid_q;
  assign request_hash_byte_pulse_out = req_q;
  assign reset_hash_out              = reset_hash_q;
  assign byte_count_out              = count_q;
  assign timeout_error_out           = error_q;

endmodule

// File: tb/tb_stream_xor_encryptor.sv
// Directed bench for stream_xor_encryptor with a keystream generator stub that answers two
// cycles after each request.
module tb_stream_xor_encryptor;

  localparam int unsigned Tmo = 16;
  localparam int unsigned Cw  = 4;

  logic          clk = 1'b0;
  logic          rst, restart, plain_valid, cipher_ready, man_pulse, stub_en;
  logic [7:0]    plain_byte, key_base;
  logic          plain_ready, cipher_valid, req, reset_hash, timeout_err;
  logic [7:0]    cipher_byte, hash_byte;
  logic          hash_pulse;
  logic [Cw-1:0] byte_count;
  logic          req_d1 = 1'b0, req_d2 = 1'b0;
  int unsigned   pulse_cnt = 0, req_cnt = 0;
  int            vectors = 0, errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    req_d1 <= req;
    req_d2 <= req_d1;
    if (req) req_cnt <= req_cnt + 1;
    if (hash_pulse) pulse_cnt <= pulse_cnt + 1;
  end

  assign hash_pulse = (stub_en & req_d2) | man_pulse;
  assign hash_byte  = key_base + pulse_cnt[7:0];

  stream_xor_encryptor #(
    .TIMEOUT_CYCLES(Tmo),
    .COUNT_WIDTH   (Cw)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .restart                    (restart),
    .plain_byte_in              (plain_byte),
    .plain_valid_in             (plain_valid),
    .plain_ready_out            (plain_ready),
    .cipher_byte_out            (cipher_byte),
    .cipher_valid_out           (cipher_valid),
    .cipher_ready_in            (cipher_ready),
    .request_hash_byte_pulse_out(req),
    .hash_byte_in               (hash_byte),
    .hash_byte_pulse_in         (hash_pulse),
    .reset_hash_out             (reset_hash),
    .byte_count_out             (byte_count),
    .timeout_error_out          (timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    vectors++; if (cipher_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", cipher_valid); end
    vectors++; if (cipher_byte !== 8'h00) begin errors++; $display("FAIL rst_byte: got %h want 00", cipher_byte); end
    vectors++; if (req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", req); end
    vectors++; if (reset_hash !== 1'b0) begin errors++; $display("FAIL rst_reset_hash: got %b want 0", reset_hash); end
    vectors++; if (byte_count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", byte_count); end
    vectors++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", timeout_err); end
    rst = 1'b0;
    #1;
    vectors++; if (plain_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", plain_ready); end
    step();
  endtask

  task automatic test_single();
    int unsigned r0;
    do_restart();
    stub_en = 1'b1;
    key_base = 8'hA5 - pulse_cnt[7:0];
    r0 = req_cnt;
    cipher_ready = 1'b1;
    plain_byte = 8'h3C;
    plain_valid = 1'b1;
    step();  // cycle 1
    plain_valid = 1'b0;
    vectors++; if (req !== 1'b1) begin errors++; $display("FAIL single_req_c1: got %b want 1", req); end
    vectors++; if (plain_ready !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", plain_ready); end
    step();  // cycle 2
    vectors++; if (req !== 1'b0) begin errors++; $display("FAIL single_req_c2: got %b want 0", req); end
    step();  // cycle 3
    vectors++; if (cipher_valid !== 1'b0) begin errors++; $display("FAIL single_valid_c3: got %b want 0", cipher_valid); end
    step();  // cycle 4
    vectors++; if (cipher_valid !== 1'b1) begin errors++; $display("FAIL single_valid_c4: got %b want 1", cipher_valid); end
    vectors++; if (cipher_byte !== 8'h99) begin errors++; $display("FAIL single_byte: got %h want 99", cipher_byte); end
    step();  // cycle 5
    vectors++; if (cipher_valid !== 1'b0) begin errors++; $display("FAIL single_valid_c5: got %b want 0", cipher_valid); end
    vectors++; if (byte_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d want 1", byte_count); end
    vectors++; if (req_cnt - r0 !== 1) begin errors++; $display("FAIL single_req_total: got %0d want 1", req_cnt - r0); end
    vectors++; if (plain_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", plain_ready); end
  endtask

  task automatic test_stream();
    int unsigned r0;
    int          n;
    logic        done;
    logic [7:0]  exp;
    do_restart();
    stub_en = 1'b1;
    key_base = 8'h10 - pulse_cnt[7:0];
    r0 = req_cnt;
    cipher_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (!plain_ready && n < 20) begin step(); n++; end
      plain_byte = 8'(i);
      plain_valid = 1'b1;
      step();
      plain_valid = 1'b0;
      exp = 8'(i) ^ (8'h10 + 8'(i));
      done = 1'b0;
      n = 0;
      while (!done && n < 40) begin
        if (cipher_valid) begin
          vectors++; if (cipher_byte !== exp) begin errors++; $display("FAIL stream_byte%0d: got %h want %h", i, cipher_byte, exp); end
          if (cipher_ready) done = 1'b1;
        end
        step();
        n++;
        cipher_ready = ~cipher_ready;
      end
      vectors++; if (done !== 1'b1) begin errors++; $display("FAIL stream_handshake%0d: got %b want 1", i, done); end
    end
    cipher_ready = 1'b1;
    vectors++; if (byte_count !== 4'd8) begin errors++; $display("FAIL stream_count: got %0d want 8", byte_count); end
    vectors++; if (req_cnt - r0 !== 8) begin errors++; $display("FAIL stream_req_total: got %0d want 8", req_cnt - r0); end
  endtask

  task automatic test_timeout();
    int unsigned r0;
    do_restart();
    stub_en = 1'b0;
    r0 = req_cnt;
    plain_byte = 8'h5A;
    plain_valid = 1'b1;
    step();  // cycle 1: request
    plain_valid = 1'b0;
    repeat (16) step();  // cycle 17: last WAIT_HASH cycle
    vectors++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", timeout_err); end
    step();  // cycle 18
    vectors++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b want 1", timeout_err); end
    vectors++; if (plain_ready !== 1'b0) begin errors++; $display("FAIL tmo_ready: got %b want 0", plain_ready); end
    man_pulse = 1'b1;
    step();
    man_pulse = 1'b0;
    step();
    vectors++; if (cipher_valid !== 1'b0) begin errors++; $display("FAIL tmo_stray_valid: got %b want 0", cipher_valid); end
    vectors++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
    vectors++; if (req_cnt - r0 !== 1) begin errors++; $display("FAIL tmo_req_total: got %0d want 1", req_cnt - r0); end
    restart = 1'b1;
    step();
    restart = 1'b0;
    vectors++; if (reset_hash !== 1'b1) begin errors++; $display("FAIL tmo_reset_hash: got %b want 1", reset_hash); end
    vectors++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", timeout_err); end
    vectors++; if (plain_ready !== 1'b0) begin errors++; $display("FAIL tmo_ready_rh: got %b want 0", plain_ready); end
    step();
    vectors++; if (reset_hash !== 1'b0) begin errors++; $display("FAIL tmo_reset_hash_end: got %b want 0", reset_hash); end
    vectors++; if (plain_ready !== 1'b1) begin errors++; $display("FAIL tmo_ready_after: got %b want 1", plain_ready); end
  endtask

  task automatic test_pulse_at_limit();
    do_restart();
    stub_en = 1'b0;
    cipher_ready = 1'b1;
    key_base = 8'hC3 - pulse_cnt[7:0];
    plain_byte = 8'h5A;
    plain_valid = 1'b1;
    step();  // cycle 1
    plain_valid = 1'b0;
    repeat (16) step();  // cycle 17: counter would hit the limit here
    man_pulse = 1'b1;
    step();
    man_pulse = 1'b0;
    vectors++; if (cipher_valid !== 1'b1) begin errors++; $display("FAIL limit_valid: got %b want 1", cipher_valid); end
    vectors++; if (cipher_byte !== 8'h99) begin errors++; $display("FAIL limit_byte: got %h want 99", cipher_byte); end
    vectors++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL limit_no_error: got %b want 0", timeout_err); end
    step();
    vectors++; if (byte_count !== 4'd1) begin errors++; $display("FAIL limit_count: got %0d want 1", byte_count); end
  endtask

  task automatic test_restart_in_wait();
    do_restart();
    stub_en = 1'b1;
    cipher_ready = 1'b1;
    plain_byte = 8'h77;
    plain_valid = 1'b1;
    step();  // cycle 1
    plain_valid = 1'b0;
    step();  // cycle 2: WAIT_HASH
    restart = 1'b1;
    step();  // cycle 3: stub pulse arrives
    restart = 1'b0;
    vectors++; if (reset_hash !== 1'b1) begin errors++; $display("FAIL rw_reset_hash: got %b want 1", reset_hash); end
    step();
    vectors++; if (cipher_valid !== 1'b0) begin errors++; $display("FAIL rw_valid: got %b want 0", cipher_valid); end
    vectors++; if (byte_count !== 4'd0) begin errors++; $display("FAIL rw_count: got %0d want 0", byte_count); end
    vectors++; if (plain_ready !== 1'b1) begin errors++; $display("FAIL rw_idle: got %b want 1", plain_ready); end
    step();
    vectors++; if (cipher_valid !== 1'b0) begin errors++; $display("FAIL rw_valid_late: got %b want 0", cipher_valid); end
  endtask

  task automatic test_wrap();
    int         n;
    logic [7:0] exp;
    do_restart();
    stub_en = 1'b1;
    cipher_ready = 1'b1;
    key_base = 8'h00 - pulse_cnt[7:0];
    for (int i = 0; i < 17; i++) begin
      n = 0;
      while (!plain_ready && n < 20) begin step(); n++; end
      plain_byte = 8'(i * 3);
      plain_valid = 1'b1;
      step();
      plain_valid = 1'b0;
      n = 0;
      while (!cipher_valid && n < 20) begin step(); n++; end
      exp = 8'(i * 3) ^ 8'(i);
      vectors++; if (cipher_byte !== exp) begin errors++; $display("FAIL wrap_byte%0d: got %h want %h", i, cipher_byte, exp); end
      step();
    end
    vectors++; if (byte_count !== 4'd1) begin errors++; $display("FAIL wrap_count: got %0d want 1", byte_count); end
  endtask

  task automatic test_async_reset();
    do_restart();
    stub_en = 1'b0;
    plain_byte = 8'h11;
    plain_valid = 1'b1;
    step();  // cycle 1: request high
    plain_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (req !== 1'b0) begin errors++; $display("FAIL arst_req: got %b want 0", req); end
    vectors++; if (plain_ready !== 1'b1) begin errors++; $display("FAIL arst_idle: got %b want 1", plain_ready); end
    step();
    rst = 1'b0;
    step();
    vectors++; if (reset_hash !== 1'b0) begin errors++; $display("FAIL arst_no_reset_hash: got %b want 0", reset_hash); end
    vectors++; if (req !== 1'b0) begin errors++; $display("FAIL arst_no_req: got %b want 0", req); end
  endtask

  initial begin
    rst = 1'b1;
    restart = 1'b0;
    plain_valid = 1'b0;
    plain_byte = 8'h00;
    cipher_ready = 1'b0;
    man_pulse = 1'b0;
    stub_en = 1'b0;
    key_base = 8'h00;
    test_reset();
    test_single();
    test_stream();
    test_timeout();
    test_pulse_at_limit();
    test_restart_in_wait();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
